// File: rtl/pipe_pkg.sv
// Shared scoreboard types and forward-select codes for the pipeline hazard controller.
// Latency: declarations only.  Backpressure: not applicable.
package pipe_pkg;

  // Widest register address a scoreboard tag can carry; narrower REG_AW values are zero-extended.
  localparam int TAG_AW = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] dst;
    logic [TAG_AW-1:0] rs;
    logic [TAG_AW-1:0] rt;
    logic              regWrite;
    logic              memToReg;
    logic              mdOp;
  } stage_tag_t;

  function automatic logic tagWrites(input stage_tag_t t, input logic [TAG_AW-1:0] r,
                                     input logic zeroReg);
    return t.valid & t.regWrite & (t.dst == r) & ~(zeroReg & (r == '0));
  endfunction

endpackage

// File: rtl/md_cnt.sv
// Loadable down-counter holding the remaining execute cycles of a multi-cycle op.
// Latency: nonZero follows the registered count.  Backpressure: none; load beats decrement, count rests at 0.
module md_cnt #(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic nonZero
);

  localparam int CW = $clog2(MD_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LAT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign nonZero = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush and forward-select control for the 5-stage pipeline, using a private E/M/W scoreboard.
// Latency: all outputs combinational from the scoreboard and D inputs.  Backpressure: stalls hold F/D (and E while busy).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MD_LAT   = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validD,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              useRsD,
  input  logic              useRtD,
  input  logic [REG_AW-1:0] dstD,
  input  logic              regWriteD,
  input  logic              memToRegD,
  input  logic              mdOpD,
  input  logic              branchD,
  input  logic              jumpD,
  input  logic              pcSrcD,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              forwardAD,
  output logic              forwardBD,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              mdBusy
);

  stage_tag_t        tagD, tagE, tagM, tagW;
  logic [TAG_AW-1:0] rsX, rtX;
  logic              eHitD, mHitD;
  logic              lwStall, brStall, hazStall;
  logic              mdLoad, cntNz;

  function automatic logic [1:0] fwdSel(input stage_tag_t m, input stage_tag_t w,
                                        input logic [TAG_AW-1:0] r);
    if (tagWrites(m, r, ZERO_REG)) return FWD_MEM;
    if (tagWrites(w, r, ZERO_REG)) return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    rsX           = TAG_AW'(rsD);
    rtX           = TAG_AW'(rtD);
    tagD          = '0;
    tagD.valid    = validD;
    tagD.dst      = TAG_AW'(dstD);
    tagD.rs       = rsX;
    tagD.rt       = rtX;
    tagD.regWrite = regWriteD;
    tagD.memToReg = memToRegD;
    tagD.mdOp     = mdOpD;
  end

  // Hits only count for operands the decoding instruction actually reads.
  always_comb begin
    eHitD = (useRsD & tagWrites(tagE, rsX, ZERO_REG)) | (useRtD & tagWrites(tagE, rtX, ZERO_REG));
    mHitD = (useRsD & tagWrites(tagM, rsX, ZERO_REG)) | (useRtD & tagWrites(tagM, rtX, ZERO_REG));
  end

  always_comb begin
    lwStall  = validD & tagE.memToReg & eHitD;
    brStall  = branchD & validD & (eHitD | (tagM.memToReg & mHitD));
    mdBusy   = tagE.valid & tagE.mdOp & cntNz;
    hazStall = lwStall | brStall;
    stallF   = hazStall | mdBusy;
    stallD   = hazStall | mdBusy;
    stallE   = mdBusy;
    flushE   = hazStall & ~mdBusy;
    flushM   = mdBusy;
    flushD   = (pcSrcD | jumpD) & ~stallD;
  end

  always_comb begin
    forwardAD = branchD & tagWrites(tagM, rsX, ZERO_REG) & ~tagM.memToReg;
    forwardBD = branchD & tagWrites(tagM, rtX, ZERO_REG) & ~tagM.memToReg;
    forwardAE = fwdSel(tagM, tagW, tagE.rs);
    forwardBE = fwdSel(tagM, tagW, tagE.rt);
  end

  // A held E keeps the multi-cycle op in place while M fills with bubbles behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tagE <= '0;
      tagM <= '0;
      tagW <= '0;
    end else begin
      if (flushE) begin
        tagE <= '0;
      end else if (!stallE) begin
        tagE <= tagD;
      end
      tagM <= flushM ? '0 : tagE;
      tagW <= tagM;
    end
  end

  assign mdLoad = validD & mdOpD & ~stallE & ~flushE;

  md_cnt #(
    .MD_LAT(MD_LAT)
  ) u_md_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (mdLoad),
    .nonZero(cntNz)
  );

  // Late-stage fields kept for debug visibility; nothing downstream consumes them.
  logic unusedTagBits;
  assign unusedTagBits = ^{tagW.rs, tagW.rt, tagW.memToReg, tagW.mdOp, tagM.rs, tagM.rt, tagM.mdOp};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario bench for pipe_hazard_ctrl: per-cycle D-stage stimulus tables with hand-derived expected outputs.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       ut;
    logic [4:0] dst;
    logic       rw;
    logic       m2r;
    logic       md;
    logic       br;
    logic       j;
    logic       pc;
  } instr_t;

  typedef struct packed {
    logic       sF;
    logic       sD;
    logic       sE;
    logic       fD;
    logic       fE;
    logic       fM;
    logic       aD;
    logic       bD;
    logic [1:0] aE;
    logic [1:0] bE;
    logic       busy;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       validD, useRsD, useRtD, regWriteD, memToRegD, mdOpD, branchD, jumpD, pcSrcD;
  logic [4:0] rsD, rtD, dstD;
  logic       stallF, stallD, stallE, flushD, flushE, flushM, forwardAD, forwardBD, mdBusy;
  logic [1:0] forwardAE, forwardBE;

  int nRun = 0;
  int nFail = 0;

  instr_t insQ[$];
  obs_t   expTab[$];
  obs_t   expQ[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .MD_LAT(4), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .validD(validD), .rsD(rsD), .rtD(rtD),
    .useRsD(useRsD), .useRtD(useRtD), .dstD(dstD), .regWriteD(regWriteD),
    .memToRegD(memToRegD), .mdOpD(mdOpD), .branchD(branchD), .jumpD(jumpD),
    .pcSrcD(pcSrcD), .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .forwardAD(forwardAD),
    .forwardBD(forwardBD), .forwardAE(forwardAE), .forwardBE(forwardBE), .mdBusy(mdBusy)
  );

  function automatic instr_t nop();
    instr_t i; i = '0; return i;
  endfunction
  function automatic instr_t alu(input logic [4:0] d, s, t);
    instr_t i; i = '0; i.v = 1; i.rs = s; i.rt = t; i.ur = 1; i.ut = 1; i.dst = d; i.rw = 1; return i;
  endfunction
  function automatic instr_t lw(input logic [4:0] d, b);
    instr_t i; i = '0; i.v = 1; i.rs = b; i.rt = d; i.ur = 1; i.dst = d; i.rw = 1; i.m2r = 1; return i;
  endfunction
  function automatic instr_t beq(input logic [4:0] s, t, input logic taken);
    instr_t i; i = '0; i.v = 1; i.rs = s; i.rt = t; i.ur = 1; i.ut = 1; i.br = 1; i.pc = taken; return i;
  endfunction
  function automatic instr_t mul(input logic [4:0] d, s, t);
    instr_t i; i = alu(d, s, t); i.md = 1; return i;
  endfunction
  function automatic instr_t jmp();
    instr_t i; i = '0; i.v = 1; i.j = 1; return i;
  endfunction

  function automatic obs_t oZero();
    obs_t o; o = '0; return o;
  endfunction
  function automatic obs_t oStall();
    obs_t o; o = '0; o.sF = 1; o.sD = 1; o.fE = 1; return o;
  endfunction
  function automatic obs_t oBusy();
    obs_t o; o = '0; o.sF = 1; o.sD = 1; o.sE = 1; o.fM = 1; o.busy = 1; return o;
  endfunction
  function automatic obs_t oFwdE(input logic [1:0] a, b);
    obs_t o; o = '0; o.aE = a; o.bE = b; return o;
  endfunction
  function automatic obs_t oRedirect(input logic aD);
    obs_t o; o = '0; o.fD = 1; o.aD = aD; return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{stallF, stallD, stallE, flushD, flushE, flushM, forwardAD, forwardBD, forwardAE, forwardBE, mdBusy};
    return o;
  endfunction

  task automatic setD(input instr_t i);
    validD = i.v; rsD = i.rs; rtD = i.rt; useRsD = i.ur; useRtD = i.ut; dstD = i.dst;
    regWriteD = i.rw; memToRegD = i.m2r; mdOpD = i.md; branchD = i.br; jumpD = i.j; pcSrcD = i.pc;
  endtask

  task automatic step(input instr_t i, input obs_t e);
    insQ.push_back(i);
    expTab.push_back(e);
  endtask

  task automatic drain();
    setD(nop());
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    instr_t r;
    logic [31:0] rv;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) rst = 1'b0;
      rv = $urandom;
      r = rv[$bits(instr_t)-1:0];
      r.j = 1'b0; r.pc = 1'b0;
      if (k >= 2) r = nop();
      setD(r);
      expQ.push_back(oZero());
      #2;
      got = sample(); want = expQ.pop_front(); nRun++;
      if (got !== want) begin
        nFail++; $display("FAIL reset cycle %0d: got %b, want %b", k, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_forwarding();
    obs_t got, want;
    insQ.delete(); expTab.delete();
    // back-to-back dependent ALU ops take the M path
    step(alu(3, 1, 2), oZero()); step(alu(4, 3, 3), oZero());
    step(nop(), oFwdE(2'b10, 2'b10)); step(nop(), oZero()); step(nop(), oZero());
    // one gap takes the W path
    step(alu(3, 1, 2), oZero()); step(nop(), oZero()); step(alu(4, 3, 3), oZero());
    step(nop(), oFwdE(2'b01, 2'b01)); step(nop(), oZero());
    // writes to $0 never forward
    step(alu(0, 1, 2), oZero()); step(alu(4, 0, 0), oZero());
    step(nop(), oZero()); step(nop(), oZero());
    // rs from W, rt from M
    step(alu(3, 1, 2), oZero()); step(alu(5, 6, 7), oZero()); step(alu(6, 3, 5), oZero());
    step(nop(), oFwdE(2'b01, 2'b10)); step(nop(), oZero());
    // M wins when M and W both write the source
    step(alu(3, 1, 2), oZero()); step(alu(3, 6, 7), oZero()); step(alu(4, 3, 1), oZero());
    step(nop(), oFwdE(2'b10, 2'b00));
    for (int k = 0; k < insQ.size(); k++) begin
      setD(insQ[k]); expQ.push_back(expTab[k]);
      #2;
      got = sample(); want = expQ.pop_front(); nRun++;
      if (got !== want) begin
        nFail++; $display("FAIL forwarding step %0d: got %b, want %b", k, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    obs_t got, want;
    insQ.delete(); expTab.delete();
    step(lw(5, 0), oZero());
    step(alu(6, 5, 1), oStall());
    step(alu(6, 5, 1), oZero());
    step(nop(), oFwdE(2'b01, 2'b00));
    step(nop(), oZero());
    for (int k = 0; k < insQ.size(); k++) begin
      setD(insQ[k]); expQ.push_back(expTab[k]);
      #2;
      got = sample(); want = expQ.pop_front(); nRun++;
      if (got !== want) begin
        nFail++; $display("FAIL load_use step %0d: got %b, want %b", k, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_alu();
    obs_t got, want;
    insQ.delete(); expTab.delete();
    step(alu(7, 1, 2), oZero());
    step(beq(7, 0, 1'b1), oStall());
    step(beq(7, 0, 1'b1), oRedirect(1'b1));
    step(nop(), oFwdE(2'b01, 2'b00));
    step(nop(), oZero());
    step(jmp(), oRedirect(1'b0));
    step(nop(), oZero());
    for (int k = 0; k < insQ.size(); k++) begin
      setD(insQ[k]); expQ.push_back(expTab[k]);
      #2;
      got = sample(); want = expQ.pop_front(); nRun++;
      if (got !== want) begin
        nFail++; $display("FAIL branch_alu step %0d: got %b, want %b", k, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_load();
    obs_t got, want;
    insQ.delete(); expTab.delete();
    step(lw(7, 0), oZero());
    step(beq(7, 0, 1'b0), oStall());
    step(beq(7, 0, 1'b0), oStall());
    step(beq(7, 0, 1'b0), oZero());
    step(nop(), oZero());
    step(lw(7, 0), oZero());
    step(nop(), oZero());
    step(beq(7, 0, 1'b0), oStall());
    step(beq(7, 0, 1'b0), oZero());
    step(nop(), oZero());
    for (int k = 0; k < insQ.size(); k++) begin
      setD(insQ[k]); expQ.push_back(expTab[k]);
      #2;
      got = sample(); want = expQ.pop_front(); nRun++;
      if (got !== want) begin
        nFail++; $display("FAIL branch_load step %0d: got %b, want %b", k, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back_md();
    obs_t got, want;
    insQ.delete(); expTab.delete();
    step(mul(8, 1, 2), oZero());
    for (int k = 0; k < 3; k++) step(mul(10, 1, 2), oBusy());
    step(mul(10, 1, 2), oZero());
    for (int k = 0; k < 3; k++) step(alu(9, 10, 4), oBusy());
    step(alu(9, 10, 4), oZero());
    step(nop(), oFwdE(2'b10, 2'b00));
    step(nop(), oZero());
    for (int k = 0; k < insQ.size(); k++) begin
      setD(insQ[k]); expQ.push_back(expTab[k]);
      #2;
      got = sample(); want = expQ.pop_front(); nRun++;
      if (got !== want) begin
        nFail++; $display("FAIL md_op step %0d: got %b, want %b", k, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_simultaneous();
    obs_t got, want;
    instr_t mx;
    mx = mul(11, 1, 2);
    mx.m2r = 1'b1;
    insQ.delete(); expTab.delete();
    step(mx, oZero());
    step(alu(12, 11, 0), oBusy());
    for (int k = 0; k < insQ.size(); k++) begin
      setD(insQ[k]); expQ.push_back(expTab[k]);
      #2;
      got = sample(); want = expQ.pop_front(); nRun++;
      if (got !== want) begin
        nFail++; $display("FAIL simultaneous step %0d: got %b, want %b", k, got, want);
      end
      @(posedge clk); #1;
    end
    setD(alu(12, 11, 0));
    expQ.push_back(oBusy());
    #2;
    got = sample(); want = expQ.pop_front(); nRun++;
    if (got !== want) begin
      nFail++; $display("FAIL simultaneous busy2: got %b, want %b", got, want);
    end
    rst = 1'b1;
    expQ.push_back(oZero());
    #1;
    got = sample(); want = expQ.pop_front(); nRun++;
    if (got !== want) begin
      nFail++; $display("FAIL simultaneous mid_reset: got %b, want %b", got, want);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    setD(nop());
    expQ.push_back(oZero());
    #2;
    got = sample(); want = expQ.pop_front(); nRun++;
    if (got !== want) begin
      nFail++; $display("FAIL simultaneous post_reset: got %b, want %b", got, want);
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    drain();
    test_load_use();
    drain();
    test_branch_alu();
    drain();
    test_branch_load();
    drain();
    test_back_to_back_md();
    drain();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1);
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It replaces the purely combinational hazard logic with a unit that keeps its own E/M/W stage scoreboard, fed from decode-stage issue information. It adds two capabilities:
- a multi-cycle execute mode for mul/div-class ops, with a configurable latency;
- optional zero-register suppression.

It sits beside the datapath and drives every stall, flush and forward-select line.

## Interface
- REG_AW, 5: register address width.
- MD_LAT, 4: execute-stage occupancy of a multi-cycle op, in cycles; legal range 1..15; 1 means single-cycle.
- ZERO_REG, 1: when 1, register 0 never matches for forwarding or stalls.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- validD  in  1  decode slot holds a real instruction.
- rsD, rtD  in  REG_AW  decode source registers.
- useRsD, useRtD  in  1  the instruction reads rs / rt.
- dstD  in  REG_AW  final destination register, after the regDst mux.
- regWriteD, memToRegD, mdOpD  in  1  writes a register; is a load; is a multi-cycle op.
- branchD, jumpD, pcSrcD  in  1  branch instruction in D; jump in D; branch taken.
- stallF, stallD, stallE  out  1  hold the PC, the F/D register and the D/E register.
- flushD, flushE, flushM  out  1  clear the F/D, D/E and E/M registers, inserting a bubble.
- forwardAD, forwardBD  out  1  compare operand comes from ALUOutM.
- forwardAE, forwardBE  out  2  ALU operand select: 00 = register file, 01 = resultW, 10 = ALUOutM.
- mdBusy  out  1  a multi-cycle op is still occupying E.

## Operation
- Scoreboard entries E, M and W each hold {valid, dst, rs, rt, regWrite, memToReg, mdOp}.
- On each rising edge, when the stage is not held:
  - D advances to E. E is cleared if flushE, and keeps its contents if stallE.
  - E advances to M. M is cleared (bubble) if flushM.
  - M advances to W unconditionally.
- A stage writes register r when valid & regWrite & dst==r & !(ZERO_REG & r==0).
- Forward to E (evaluated for rs, and likewise rt):
  - 10 if M writes rsE;
  - else 01 if W writes rsE;
  - else 00.
  - M has priority over W.
- Forward to D: forwardAD = branchD & M writes rsD & !M.memToReg. forwardBD is the same with rt.
- No W-to-D forward. The register file writes on the falling edge, so W data reaches D through the register file.
- lwStall: validD & E.valid & E.memToReg & E writes a used rs or rt.
- brStall: branchD & validD, and either:
  - E writes a used rs or rt, or
  - M is a load that writes a used rs or rt.
- mdBusy: E.valid & E.mdOp & cnt!=0.
- stallF = stallD = lwStall | brStall | mdBusy.
- stallE = mdBusy.
- flushE = (lwStall | brStall) & !mdBusy.
- flushM = mdBusy.
- flushD = (pcSrcD | jumpD) & !stallD. A stall always wins over a redirect flush; the redirect is re-evaluated on the next cycle.
- Multi-cycle counter cnt is $clog2(MD_LAT+1) bits wide:
  - loaded with MD_LAT-1 when an mdOp enters E;
  - decremented while nonzero;
  - with MD_LAT=1 it stays 0 and mdBusy never asserts.
- Back-to-back mdOps: the second enters E on the edge where the first leaves, and cnt reloads.

## Timing
- Reset (asynchronous): all scoreboard valids = 0 and cnt = 0.
  - Every output except flushD is 0 immediately.
  - flushD is 0 whenever jumpD and pcSrcD are 0.
- All outputs are combinational from the scoreboard plus the D inputs; zero-cycle latency, valid in the same cycle.
- A load followed by a dependent instruction costs 1 stall cycle, then forwardXE = 01.
- A dependent ALU op with no gap gets forwardXE = 10 with no stall.
- A branch depending on the immediately preceding ALU op stalls 1 cycle, then forwardXD = 1.
- A branch depending on a load two ahead stalls 1 cycle; one directly ahead stalls 2 cycles.
- An mdOp occupies E for MD_LAT cycles:
  - stallF, stallD and stallE are high for MD_LAT-1 cycles;
  - flushM is high for the same MD_LAT-1 cycles, so that many bubbles enter M.
- Reset asserted mid-mdOp: cnt and the scoreboard clear asynchronously and the stalls drop in the same cycle.

## Structure
- Shared package pipe_pkg:
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - packed struct stage_tag_t {valid, dst, rs, rt, regWrite, memToReg, mdOp}.
- One sub-module, md_cnt: a loadable down-counter with a nonzero flag, parametrised by MD_LAT.

## Test plan
- Reset check: rst high for 2 cycles with random D inputs, jumpD = pcSrcD = 0 → every output is 0. Release rst → outputs are still 0 with validD=0.
- Forwarding: `add $3,$1,$2` then `sub $4,$3,$3` → forwardAE = forwardBE = 10. Insert one nop between them → 01. Use $0 as the destination with ZERO_REG=1 → 00.
- Load-use: `lw $5,0($0)` then `add $6,$5,$1` → stallF=stallD=flushE=1 for exactly 1 cycle, then forwardAE=01.
- Branch hazards:
  - `add $7,..` then `beq $7,$0` → brStall for 1 cycle, then forwardAD=1, pcSrcD=1 → flushD=1.
  - `lw $7` then `beq $7` → 2 stall cycles.
- Multi-cycle with MD_LAT=4: an mdOp followed by an independent add → mdBusy, stallE and flushM high for 3 cycles; the add enters E on the 4th edge. A second mdOp back-to-back → 3 more busy cycles.
- Simultaneous events: during mdBusy, present a load-use pair in D and E → flushE=0 and E is held. Assert rst in the 2nd busy cycle → mdBusy=0 in the same cycle.
